qic117_status_decoder: RTL and testbench
========================================

QIC117_STATUS_DECODER -- requirements
Module: qic117_status_decoder

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 200_000_000, system clock frequency in Hz; CLKS_PER_US = CLK_FREQ_HZ/1_000_000.
REQ-002 Parameter MIN_LOW_US, default 250, shortest accepted low pulse; shorter lows are glitches.
REQ-003 Parameter THRESH_US, default 1000, bit-0/bit-1 decision threshold on low width.
REQ-004 Parameter MAX_LOW_US, default 2500, longest legal low pulse.
REQ-005 Parameter GAP_TIMEOUT_US, default 5000, longest legal high gap inside a word.
REQ-006 Ports SHALL be, in this order:
 clk  in  1  single system clock, rising edge.
 reset_n  in  1  synchronous, active-low reset.
 enable  in  1  decoder active (tape mode).
 trk0_in  in  1  raw TRK0 line from the drive interface, asynchronous, idle high.
 bit_valid  out  1  one-cycle pulse, one bit decoded.
 bit_value  out  1  value of the last decoded bit, held until the next bit_valid.
 word_valid  out  1  one-cycle pulse, 8 bits received.
 status_word  out  8  last complete word, MSB first on the wire; held until the next word_valid.
 pulse_err  out  1  one-cycle pulse, low pulse wider than MAX_LOW_US.
 gap_err  out  1  one-cycle pulse, gap timeout with a partial word.
 busy  out  1  high from the first accepted falling edge until the word completes or aborts.
 bit_count  out  4  bits received in the current word, 0-8.

Function
REQ-007 trk0_in SHALL pass through a 2-flop synchronizer, reset value 1, before edge detection.
REQ-008 The FSM SHALL have states IDLE, LOW, GAP and STUCK. Reset and disabled state is IDLE.
REQ-009 IDLE: on a synchronized falling edge, clear the width counter, enter LOW, and assert busy.
REQ-010 LOW: increment the width counter by 1 every cycle. The counter saturates at MAX_LOW_US*CLKS_PER_US and is sized by $clog2 of its largest terminal count plus 1.
REQ-011 LOW, rising edge with width < MIN_LOW_US*CLKS_PER_US: discard as a glitch with no output pulse.
 - Return to IDLE if bit_count==0, otherwise to GAP.
 - The gap counter restarts at 0.
REQ-012 LOW, rising edge with width < THRESH_US*CLKS_PER_US: decode bit 0. Otherwise decode bit 1.
 - Shift the bit into the word shift register from the LSB side.
 - Increment bit_count.
 - Pulse bit_valid.
 - Enter GAP.
REQ-013 When a decoded bit is the 8th bit:
 - In the same cycle as its bit_valid, load status_word and pulse word_valid.
 - Next cycle: bit_count=0, busy=0, state IDLE.
REQ-014 LOW, width reaching MAX_LOW_US*CLKS_PER_US while still low:
 - Pulse pulse_err and discard the partial word (bit_count=0).
 - Enter STUCK. STUCK waits for a rising edge, then goes to IDLE.
 - busy stays high in STUCK.
REQ-015 GAP: count high cycles. A falling edge enters LOW with the width counter cleared.
 - If the count reaches GAP_TIMEOUT_US*CLKS_PER_US, pulse gap_err, clear bit_count and busy, and go to IDLE.
 - status_word is unchanged.
REQ-016 Latency, macro absent: bit_valid asserts exactly 3 clk cycles after the first clk edge that samples trk0_in high.
REQ-017 enable low SHALL force IDLE and clear bit_count, busy and all pulse outputs in the next cycle; status_word and bit_value are retained.
REQ-018 Error and valid pulses are mutually exclusive in any cycle. At most one of bit_valid, pulse_err and gap_err is high per cycle.

Reset
REQ-019 On a clk edge with reset_n==0, the reset values SHALL be:
 - Outputs: status_word=0, bit_value=0, bit_count=0, busy=0, all pulses 0.
 - Internal: synchronizer flops=1, state=IDLE, counters=0.
REQ-020 A reset applied mid-word SHALL abandon the word with no word_valid or error pulse.

Configuration
REQ-021 Macro QIC117_TRK0_DEGLITCH_EN, when defined:
 - Inserts a stability filter after the synchronizer. The filtered level changes only after the synchronized input differs from it for 16 consecutive cycles.
 - Filter reset value is 1.
 - REQ-016 latency becomes 19 cycles.
 - Filter state is cleared to 1 when enable is low.
REQ-022 When the macro is undefined, no filter logic exists and the synchronizer output feeds edge detection directly.

Verification (bench uses CLK_FREQ_HZ=1_000_000, so 1 cycle = 1 us)
REQ-023 Lows of 1500,500,1500,500,500,1500,0-gap... i.e. word 0xA6 sent as lows {1500,500,1500,500,500,1500,1500,500}, each followed by a 1000 high -> 8 bit_valid pulses, word_valid once, status_word=0xA6, bit_count returns 0.
REQ-024 Low of 100 between two valid bits -> no bit_valid, bit_count unchanged, no error.
REQ-025 trk0_in held low for 3000 -> pulse_err at cycle 2500 of the low, no bit_valid, busy falls after the line rises.
REQ-026 3 valid bits then line high for 6000 -> gap_err 5000 cycles after the 3rd rising edge, status_word keeps the previous value.
REQ-027 reset_n low for 1 cycle after 4 bits -> all outputs at reset values, no pulses; the next full word 0x81 decodes correctly.
REQ-028 Single low of 999 then 1000 (macro off) -> bit_value 0 then 1; bit_valid 3 cycles after each rising edge.

Source files
------------

// File: rtl/qic117_status_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qic117_status_decoder : decodes QIC-117 pulse-width status bits on TRK0. |
// | Optional TRK0 stability filter: define QIC117_TRK0_DEGLITCH_EN.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module qic117_status_decoder #(
  parameter int CLK_FREQ_HZ    = 200_000_000,
  parameter int MIN_LOW_US     = 250,
  parameter int THRESH_US      = 1000,
  parameter int MAX_LOW_US     = 2500,
  parameter int GAP_TIMEOUT_US = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       trk0_in,
  output logic       bit_valid,
  output logic       bit_value,
  output logic       word_valid,
  output logic [7:0] status_word,
  output logic       pulse_err,
  output logic       gap_err,
  output logic       busy,
  output logic [3:0] bit_count
);

  localparam int CLKS_PER_US  = CLK_FREQ_HZ / 1_000_000;
  localparam int C_MIN_CLKS   = MIN_LOW_US * CLKS_PER_US;
  localparam int C_THR_CLKS   = THRESH_US * CLKS_PER_US;
  localparam int C_MAX_CLKS   = MAX_LOW_US * CLKS_PER_US;
  localparam int C_GAP_CLKS   = GAP_TIMEOUT_US * CLKS_PER_US;
  localparam int WIDTH_W      = $clog2(C_MAX_CLKS) + 1;
  localparam int GAP_W        = $clog2(C_GAP_CLKS) + 1;

  localparam logic [WIDTH_W-1:0] C_MIN_W = WIDTH_W'(C_MIN_CLKS);
  localparam logic [WIDTH_W-1:0] C_THR_W = WIDTH_W'(C_THR_CLKS);
  localparam logic [WIDTH_W-1:0] C_MAX_W = WIDTH_W'(C_MAX_CLKS);
  localparam logic [GAP_W-1:0]   C_GAP_G = GAP_W'(C_GAP_CLKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOW   = 2'd1,
    S_GAP   = 2'd2,
    S_STUCK = 2'd3
  } state_t;

  logic r_sync1;
  logic r_sync2;
  logic w_line;
  logic r_line_d;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= trk0_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef QIC117_TRK0_DEGLITCH_EN
  logic       r_filt;
  logic [3:0] r_filt_cnt;

  // Level follows the synchronized line only after 16 consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      r_filt     <= 1'b1;
      r_filt_cnt <= 4'd0;
    end else if (r_sync2 != r_filt) begin
      if (r_filt_cnt == 4'd15) begin
        r_filt     <= r_sync2;
        r_filt_cnt <= 4'd0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 4'd1;
      end
    end else begin
      r_filt_cnt <= 4'd0;
    end
  end

  assign w_line = r_filt;
`else
  assign w_line = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_line_d <= 1'b1;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_line_d <= w_line;
      r_rise   <= w_line & ~r_line_d;
      r_fall   <= ~w_line & r_line_d;
    end
  end

  state_t             r_state;
  logic [WIDTH_W-1:0] r_width;
  logic [GAP_W-1:0]   r_gap;
  logic [6:0]         r_shift;
  logic [WIDTH_W-1:0] w_width_next;
  logic [GAP_W-1:0]   w_gap_next;
  logic               w_bit;

  // Width/gap "next" values count the current cycle, so a low of N cycles measures N.
  assign w_width_next = (r_width == C_MAX_W) ? r_width : r_width + 1'b1;
  assign w_gap_next   = (r_gap == C_GAP_G) ? r_gap : r_gap + 1'b1;
  assign w_bit        = (w_width_next >= C_THR_W);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_width     <= '0;
      r_gap       <= '0;
      r_shift     <= '0;
      bit_valid   <= 1'b0;
      bit_value   <= 1'b0;
      word_valid  <= 1'b0;
      status_word <= 8'd0;
      pulse_err   <= 1'b0;
      gap_err     <= 1'b0;
      busy        <= 1'b0;
      bit_count   <= 4'd0;
    end else begin
      bit_valid  <= 1'b0;
      word_valid <= 1'b0;
      pulse_err  <= 1'b0;
      gap_err    <= 1'b0;
      if (!enable) begin
        r_state   <= S_IDLE;
        r_width   <= '0;
        r_gap     <= '0;
        busy      <= 1'b0;
        bit_count <= 4'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_fall) begin
              r_width <= '0;
              busy    <= 1'b1;
              r_state <= S_LOW;
            end
          end
          S_LOW: begin
            r_width <= w_width_next;
            if (r_rise) begin
              r_gap <= '0;
              if (w_width_next < C_MIN_W) begin
                busy    <= (bit_count != 4'd0);
                r_state <= (bit_count == 4'd0) ? S_IDLE : S_GAP;
              end else begin
                bit_value <= w_bit;
                bit_valid <= 1'b1;
                r_shift   <= {r_shift[5:0], w_bit};
                bit_count <= bit_count + 4'd1;
                r_state   <= S_GAP;
                if (bit_count == 4'd7) begin
                  status_word <= {r_shift, w_bit};
                  word_valid  <= 1'b1;
                end
              end
            end else if (w_width_next == C_MAX_W) begin
              pulse_err <= 1'b1;
              bit_count <= 4'd0;
              r_state   <= S_STUCK;
            end
          end
          S_GAP: begin
            if (r_fall) begin
              r_width <= '0;
              r_state <= S_LOW;
              if (bit_count == 4'd8) begin
                bit_count <= 4'd0;
              end
            end else if (bit_count == 4'd8) begin
              bit_count <= 4'd0;
              busy      <= 1'b0;
              r_state   <= S_IDLE;
            end else if (w_gap_next == C_GAP_G) begin
              gap_err   <= 1'b1;
              bit_count <= 4'd0;
              busy      <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_gap <= w_gap_next;
            end
          end
          S_STUCK: begin
            if (r_rise) begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qic117_status_decoder.sv
`default_nettype none
// Randomized + directed bench for qic117_status_decoder against a pulse-level reference model.
module tb_qic117_status_decoder;

  localparam int MIN_C  = 250;
  localparam int THR_C  = 1000;
  localparam int MAX_C  = 2500;
  localparam int GAP_C  = 5000;
  localparam int LAT    = 3;
  localparam int K_BIT  = 1;
  localparam int K_WORD = 2;
  localparam int K_PERR = 3;
  localparam int K_GERR = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       trk0_in = 1'b1;
  logic       bit_valid;
  logic       bit_value;
  logic       word_valid;
  logic [7:0] status_word;
  logic       pulse_err;
  logic       gap_err;
  logic       busy;
  logic [3:0] bit_count;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int obs_q[$];

  int         m_cnt = 0;
  int         m_gap_start = 0;
  logic [7:0] m_word = 8'd0;
  logic [7:0] m_status = 8'd0;
  logic       m_last = 1'b0;

  qic117_status_decoder #(
    .CLK_FREQ_HZ(1_000_000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .trk0_in    (trk0_in),
    .bit_valid  (bit_valid),
    .bit_value  (bit_value),
    .word_valid (word_valid),
    .status_word(status_word),
    .pulse_err  (pulse_err),
    .gap_err    (gap_err),
    .busy       (busy),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ev(input int c, input int k, input int v);
    return c * 1024 + k * 256 + v;
  endfunction

  always @(negedge clk) begin
    if (bit_valid)  obs_q.push_back(ev(cyc, K_BIT, int'(bit_value)));
    if (word_valid) obs_q.push_back(ev(cyc, K_WORD, int'(status_word)));
    if (pulse_err)  obs_q.push_back(ev(cyc, K_PERR, 0));
    if (gap_err)    obs_q.push_back(ev(cyc, K_GERR, 0));
    if (bit_valid || pulse_err || gap_err)
      check_eq("pulse_excl", int'(bit_valid) + int'(pulse_err) + int'(gap_err), 1);
  end

  // Reference model: one low of n cycles whose first low sample is at edge f0.
  task automatic model_low(input int f0, input int n);
    logic b;
    if (n > MAX_C) begin
      exp_q.push_back(ev(f0 + LAT + MAX_C, K_PERR, 0));
      m_cnt = 0;
    end else if (n < MIN_C) begin
      if (m_cnt > 0) m_gap_start = f0 + n;
    end else begin
      b = (n >= THR_C);
      m_word = {m_word[6:0], b};
      m_last = b;
      m_cnt++;
      m_gap_start = f0 + n;
      exp_q.push_back(ev(f0 + n + LAT, K_BIT, int'(b)));
      if (m_cnt == 8) begin
        exp_q.push_back(ev(f0 + n + LAT, K_WORD, int'(m_word)));
        m_status = m_word;
        m_cnt = 0;
      end
    end
  endtask

  task automatic model_high(input int h);
    if (m_cnt > 0 && h > GAP_C) begin
      exp_q.push_back(ev(m_gap_start + LAT + GAP_C, K_GERR, 0));
      m_cnt = 0;
    end
  endtask

  task automatic compare_events(input string tag);
    check_eq({tag, "_nevents"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq({tag, "_event"}, obs_q[i], exp_q[i]);
    exp_q.delete();
    obs_q.delete();
  endtask

  // Drives a low of n cycles then a high of h cycles; entered and left #1 after a posedge.
  task automatic seg(input int n, input int h);
    int f0;
    trk0_in = 1'b0;
    f0 = cyc + 1;
    if (n >= 10) begin
      repeat (n - 5) @(posedge clk);
      #1;
      check_eq("busy_low", int'(busy), 1);
      repeat (5) @(posedge clk);
    end else begin
      repeat (n) @(posedge clk);
    end
    #1;
    trk0_in = 1'b1;
    model_low(f0, n);
    repeat (h) @(posedge clk);
    #1;
    model_high(h);
    check_eq("bit_count", int'(bit_count), m_cnt);
    check_eq("busy", int'(busy), (m_cnt != 0) ? 1 : 0);
    check_eq("status_word", int'(status_word), int'(m_status));
    check_eq("bit_value", int'(bit_value), int'(m_last));
    compare_events("seg");
  endtask

  task automatic send_word(input logic [7:0] w, input int h);
    for (int i = 7; i >= 0; i--) seg(w[i] ? 1500 : 500, h);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_status_word"}, int'(status_word), 0);
    check_eq({tag, "_bit_value"}, int'(bit_value), 0);
    check_eq({tag, "_bit_count"}, int'(bit_count), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_pulses"}, int'({bit_valid, word_valid, pulse_err, gap_err}), 0);
  endtask

  initial begin
    int r;
    int n;
    int h;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    send_word(8'hA6, 1000);
    check_eq("word_a6", int'(status_word), 8'hA6);

    seg(999, 300);
    check_eq("bit_999", int'(bit_value), 0);
    seg(1000, 300);
    check_eq("bit_1000", int'(bit_value), 1);
    seg(100, 300);
    check_eq("glitch_count", int'(bit_count), 2);
    seg(600, 6000);
    check_eq("gap_keep_word", int'(status_word), 8'hA6);

    seg(3000, 300);
    check_eq("stuck_busy_after", int'(busy), 0);

    seg(1500, 300);
    seg(500, 300);
    seg(500, 300);
    seg(1500, 300);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_cnt = 0;
    m_status = 8'd0;
    m_last = 1'b0;
    check_reset_outputs("midword_reset");
    repeat (3) @(posedge clk);
    #1;
    compare_events("midword_reset");
    send_word(8'h81, 300);
    check_eq("word_81", int'(status_word), 8'h81);

    seg(500, 300);
    seg(1500, 300);
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    m_cnt = 0;
    check_eq("dis_bit_count", int'(bit_count), 0);
    check_eq("dis_busy", int'(busy), 0);
    check_eq("dis_status_word", int'(status_word), 8'h81);
    check_eq("dis_bit_value", int'(bit_value), 1);
    repeat (3) @(posedge clk);
    #1;
    compare_events("disable");

    for (int k = 0; k < 20; k++) begin
      r = int'($urandom_range(0, 15));
      if (r < 2)       n = int'($urandom_range(20, 200));
      else if (r == 2) n = int'($urandom_range(2600, 2800));
      else if (r < 10) n = int'($urandom_range(260, 900));
      else             n = int'($urandom_range(1000, 1400));
      if ($urandom_range(0, 15) == 0) h = int'($urandom_range(5100, 5300));
      else                            h = int'($urandom_range(20, 600));
      seg(n, h);
    end

    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
